// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - openMIPS execute stage: logic/shift/move ops, HI/LO forwarding
// and an iterative 32-cycle restoring divider that stalls the pipeline.
module ex_stage #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        mem_whilo_i,
  input  logic [31:0] mem_hi_i,
  input  logic [31:0] mem_lo_i,
  input  logic        wb_whilo_i,
  input  logic [31:0] wb_hi_i,
  input  logic [31:0] wb_lo_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o
);

  localparam logic [2:0] RES_LOGIC = 3'b001;
  localparam logic [2:0] RES_SHIFT = 3'b010;
  localparam logic [2:0] RES_MOVE  = 3'b011;

  localparam logic [7:0] OP_AND  = 8'b0010_0100;
  localparam logic [7:0] OP_OR   = 8'b0010_0101;
  localparam logic [7:0] OP_XOR  = 8'b0010_0110;
  localparam logic [7:0] OP_NOR  = 8'b0010_0111;
  localparam logic [7:0] OP_SLL  = 8'b0111_1100;
  localparam logic [7:0] OP_SRL  = 8'b0000_0010;
  localparam logic [7:0] OP_SRA  = 8'b0000_0011;
  localparam logic [7:0] OP_MOVZ = 8'b0000_1010;
  localparam logic [7:0] OP_MOVN = 8'b0000_1011;
  localparam logic [7:0] OP_MFHI = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI = 8'b0001_0001;
  localparam logic [7:0] OP_MFLO = 8'b0001_0010;
  localparam logic [7:0] OP_MTLO = 8'b0001_0011;
  localparam logic [7:0] OP_DIV  = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU = 8'b0001_1011;

  localparam int CW = $clog2(DIV_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} div_state_t;

  div_state_t     r_state;
  logic [CW-1:0]  r_cnt;
  logic [64:0]    r_sr;
  logic [31:0]    r_divisor;
  logic           r_qneg;
  logic           r_rneg;

  logic [31:0] w_hi, w_lo;
  logic [31:0] w_logic, w_shift, w_move, w_wdata;
  logic        w_is_div, w_signed;
  logic [32:0] w_trial;
  logic [64:0] w_step;
  logic [31:0] w_quot, w_rem;
  logic        w_whilo;
  logic [31:0] w_hi_out, w_lo_out;
  logic        w_stall;

  // MEM is the younger writer, so it wins over WB.
  always_comb begin
    if (mem_whilo_i) begin
      w_hi = mem_hi_i;
      w_lo = mem_lo_i;
    end else if (wb_whilo_i) begin
      w_hi = wb_hi_i;
      w_lo = wb_lo_i;
    end else begin
      w_hi = hi_i;
      w_lo = lo_i;
    end
  end

  always_comb begin
    w_logic = 32'h0;
    case (aluop_i)
      OP_OR:   w_logic = reg1_i | reg2_i;
      OP_AND:  w_logic = reg1_i & reg2_i;
      OP_XOR:  w_logic = reg1_i ^ reg2_i;
      OP_NOR:  w_logic = ~(reg1_i | reg2_i);
      default: w_logic = 32'h0;
    endcase
  end

  always_comb begin
    w_shift = 32'h0;
    case (aluop_i)
      OP_SLL:  w_shift = reg2_i << reg1_i[4:0];
      OP_SRL:  w_shift = reg2_i >> reg1_i[4:0];
      OP_SRA:  w_shift = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
      default: w_shift = 32'h0;
    endcase
  end

  always_comb begin
    w_move = 32'h0;
    case (aluop_i)
      OP_MFHI:          w_move = w_hi;
      OP_MFLO:          w_move = w_lo;
      OP_MOVZ, OP_MOVN: w_move = reg1_i;
      default:          w_move = 32'h0;
    endcase
  end

  always_comb begin
    w_wdata = 32'h0;
    case (alusel_i)
      RES_LOGIC: w_wdata = w_logic;
      RES_SHIFT: w_wdata = w_shift;
      RES_MOVE:  w_wdata = w_move;
      default:   w_wdata = 32'h0;
    endcase
  end

  assign w_is_div = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
  assign w_signed = (aluop_i == OP_DIV);

  // r_sr holds {partial remainder (33), dividend/quotient bits (32)}, pre-shifted by one,
  // so after the last step the remainder sits in [64:33] and the quotient in [31:0].
  assign w_trial = r_sr[64:32] - {1'b0, r_divisor};
  assign w_step  = w_trial[32] ? {r_sr[63:0], 1'b0}
                               : {w_trial[31:0], r_sr[31:0], 1'b1};

  assign w_quot = r_qneg ? (~r_sr[31:0] + 32'd1) : r_sr[31:0];
  assign w_rem  = r_rneg ? (~r_sr[64:33] + 32'd1) : r_sr[64:33];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_sr      <= '0;
      r_divisor <= '0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
    end else if (flush_i) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_div) begin
            r_cnt     <= '0;
            r_divisor <= (w_signed && reg2_i[31]) ? (~reg2_i + 32'd1) : reg2_i;
            r_sr      <= {32'h0, ((w_signed && reg1_i[31]) ? (~reg1_i + 32'd1) : reg1_i), 1'b0};
            r_qneg    <= w_signed && (reg1_i[31] ^ reg2_i[31]);
            r_rneg    <= w_signed && reg1_i[31];
            r_state   <= (reg2_i == 32'h0) ? S_BYZERO : S_ON;
          end
        end
        S_BYZERO: begin
          r_sr    <= '0;
          r_state <= S_END;
        end
        S_ON: begin
          r_sr  <= w_step;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(DIV_CYCLES - 1))
            r_state <= S_END;
        end
        S_END: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_stall = 1'b0;
    if (!flush_i) begin
      case (r_state)
        S_IDLE:         w_stall = w_is_div;
        S_BYZERO, S_ON: w_stall = 1'b1;
        default:        w_stall = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_whilo  = 1'b0;
    w_hi_out = 32'h0;
    w_lo_out = 32'h0;
    if (r_state == S_END) begin
      if (!flush_i) begin
        w_whilo  = 1'b1;
        w_hi_out = w_rem;
        w_lo_out = w_quot;
      end
    end else if (aluop_i == OP_MTHI) begin
      w_whilo  = 1'b1;
      w_hi_out = reg1_i;
      w_lo_out = w_lo;
    end else if (aluop_i == OP_MTLO) begin
      w_whilo  = 1'b1;
      w_hi_out = w_hi;
      w_lo_out = reg1_i;
    end
  end

  assign wd_o       = rst ? 5'h0  : wd_i;
  assign wreg_o     = rst ? 1'b0  : wreg_i;
  assign wdata_o    = rst ? 32'h0 : w_wdata;
  assign whilo_o    = rst ? 1'b0  : w_whilo;
  assign hi_o       = rst ? 32'h0 : w_hi_out;
  assign lo_o       = rst ? 32'h0 : w_lo_out;
  assign stallreq_o = rst ? 1'b0  : w_stall;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed self-checking bench for ex_stage
module tb_ex_stage;

  localparam logic [2:0] RES_NOP   = 3'b000;
  localparam logic [2:0] RES_LOGIC = 3'b001;
  localparam logic [2:0] RES_SHIFT = 3'b010;
  localparam logic [2:0] RES_MOVE  = 3'b011;
  localparam logic [7:0] OP_NOP  = 8'b0000_0000;
  localparam logic [7:0] OP_AND  = 8'b0010_0100;
  localparam logic [7:0] OP_OR   = 8'b0010_0101;
  localparam logic [7:0] OP_XOR  = 8'b0010_0110;
  localparam logic [7:0] OP_NOR  = 8'b0010_0111;
  localparam logic [7:0] OP_SLL  = 8'b0111_1100;
  localparam logic [7:0] OP_SRL  = 8'b0000_0010;
  localparam logic [7:0] OP_SRA  = 8'b0000_0011;
  localparam logic [7:0] OP_MOVN = 8'b0000_1011;
  localparam logic [7:0] OP_MFHI = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI = 8'b0001_0001;
  localparam logic [7:0] OP_MFLO = 8'b0001_0010;
  localparam logic [7:0] OP_MTLO = 8'b0001_0011;
  localparam logic [7:0] OP_DIV  = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU = 8'b0001_1011;

  logic        clk = 1'b0;
  logic        rst, flush_i;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i, reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] hi_i, lo_i;
  logic        mem_whilo_i, wb_whilo_i;
  logic [31:0] mem_hi_i, mem_lo_i, wb_hi_i, wb_lo_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o, lo_o;
  logic        stallreq_o;

  int ncmp = 0;
  int nfail = 0;
  int n;
  logic seen;

  ex_stage dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .aluop_i(aluop_i), .alusel_i(alusel_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .hi_i(hi_i), .lo_i(lo_i),
    .mem_whilo_i(mem_whilo_i), .mem_hi_i(mem_hi_i), .mem_lo_i(mem_lo_i),
    .wb_whilo_i(wb_whilo_i), .wb_hi_i(wb_hi_i), .wb_lo_i(wb_lo_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [7:0] op, input logic [2:0] sel,
                        input logic [31:0] r1, input logic [31:0] r2);
    aluop_i  = op;
    alusel_i = sel;
    reg1_i   = r1;
    reg2_i   = r2;
    #1;
  endtask

  task automatic run_div(input string tag, input logic [7:0] op, input logic [31:0] r1,
                         input logic [31:0] r2, input int exp_stall,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    set_op(op, RES_NOP, r1, r2);
    n = 0;
    seen = 1'b0;
    while (stallreq_o === 1'b1 && n < 40) begin
      seen = seen | whilo_o;
      n++;
      tick();
    end
    chk({tag, " stall cycles"}, 128'(n), 128'(exp_stall));
    chk({tag, " no early whilo"}, 128'(seen), 128'(0));
    chk({tag, " end {stall,whilo,lo,hi}"}, {stallreq_o, whilo_o, lo_o, hi_o},
        {1'b0, 1'b1, exp_lo, exp_hi});
    tick();
    set_op(OP_NOP, RES_NOP, 32'h0, 32'h0);
    chk({tag, " idle after end"}, {stallreq_o, whilo_o}, 2'b00);
  endtask

  task automatic abort_div(input string tag, input logic use_rst);
    set_op(OP_DIV, RES_NOP, 32'd1000, 32'd3);
    for (int i = 0; i < 10; i++) tick();
    chk({tag, " busy before abort"}, 128'(stallreq_o), 128'(1));
    if (use_rst) rst = 1'b1; else flush_i = 1'b1;
    #1;
    if (use_rst)
      chk({tag, " all outputs zero"}, {wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o}, 128'(0));
    else
      chk({tag, " stall drops"}, {stallreq_o, whilo_o}, 2'b00);
    tick();
    rst = 1'b0;
    flush_i = 1'b0;
    set_op(OP_NOP, RES_NOP, 32'h0, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      seen = seen | whilo_o | stallreq_o;
      tick();
    end
    chk({tag, " no whilo after abort"}, 128'(seen), 128'(0));
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0;
    wd_i = 5'd3; wreg_i = 1'b1;
    hi_i = 32'h0; lo_i = 32'h0;
    mem_whilo_i = 1'b0; mem_hi_i = 32'h0; mem_lo_i = 32'h0;
    wb_whilo_i = 1'b0; wb_hi_i = 32'h0; wb_lo_i = 32'h0;
    set_op(OP_OR, RES_LOGIC, 32'h0000FF00, 32'h00F0F0F0);
    tick();
    tick();
    chk("reset outputs", {wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o}, 128'(0));
    rst = 1'b0;
    #1;

    chk("or", {wd_o, wreg_o, wdata_o}, {5'd3, 1'b1, 32'h00F0FFF0});
    chk("or no whilo", {whilo_o, hi_o, lo_o}, 65'h0);
    set_op(OP_AND, RES_LOGIC, 32'h0000FF00, 32'h00F0F0F0);
    chk("and", wdata_o, 32'h0000F000);
    set_op(OP_XOR, RES_LOGIC, 32'h0000FF00, 32'h00F0F0F0);
    chk("xor", wdata_o, 32'h00F00FF0);
    wreg_i = 1'b0;
    set_op(OP_NOR, RES_LOGIC, 32'h0000FF00, 32'h00F0F0F0);
    chk("nor", {wreg_o, wdata_o}, {1'b0, 32'hFF0F000F});
    wreg_i = 1'b1;

    set_op(OP_SRA, RES_SHIFT, 32'd4, 32'h80000000);
    chk("sra", wdata_o, 32'hF8000000);
    set_op(OP_SRL, RES_SHIFT, 32'd4, 32'h80000000);
    chk("srl", wdata_o, 32'h08000000);
    set_op(OP_SLL, RES_SHIFT, 32'h24, 32'h0000000F);
    chk("sll uses shamt[4:0]", wdata_o, 32'h000000F0);
    set_op(OP_SRA, RES_SHIFT, 32'd31, 32'h7FFFFFFF);
    chk("sra positive by 31", wdata_o, 32'h0);

    hi_i = 32'd1; wb_whilo_i = 1'b1; wb_hi_i = 32'd2; mem_whilo_i = 1'b1; mem_hi_i = 32'd3;
    set_op(OP_MFHI, RES_MOVE, 32'h0, 32'h0);
    chk("mfhi mem priority", wdata_o, 32'd3);
    mem_whilo_i = 1'b0;
    #1;
    chk("mfhi wb forward", wdata_o, 32'd2);
    lo_i = 32'h11; wb_lo_i = 32'h55;
    set_op(OP_MFLO, RES_MOVE, 32'h0, 32'h0);
    chk("mflo wb forward", wdata_o, 32'h55);
    set_op(OP_MTHI, RES_NOP, 32'hAA, 32'h0);
    chk("mthi", {whilo_o, hi_o, lo_o}, {1'b1, 32'hAA, 32'h55});
    wb_whilo_i = 1'b0;
    set_op(OP_MTLO, RES_NOP, 32'hBB, 32'h0);
    chk("mtlo", {whilo_o, hi_o, lo_o}, {1'b1, 32'd1, 32'hBB});
    set_op(OP_MOVN, RES_MOVE, 32'h1234, 32'h1);
    chk("movn", {wdata_o, whilo_o}, {32'h1234, 1'b0});
    set_op(OP_OR, 3'b111, 32'hFFFF, 32'hFFFF);
    chk("unknown alusel", wdata_o, 32'h0);
    set_op(OP_NOP, RES_NOP, 32'h0, 32'h0);
    tick();

    run_div("div -7/2", OP_DIV, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFD, 32'hFFFFFFFF);
    run_div("divu", OP_DIVU, 32'hFFFFFFFF, 32'h10, 33, 32'h0FFFFFFF, 32'hF);
    run_div("div by zero", OP_DIV, 32'd77, 32'd0, 2, 32'h0, 32'h0);
    run_div("div min/-1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 33, 32'h80000000, 32'h0);
    run_div("div 100/-7", OP_DIV, 32'd100, 32'hFFFFFFF9, 33, 32'hFFFFFFF2, 32'd2);

    abort_div("flush", 1'b0);
    abort_div("rst", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, compared %0d", ncmp);
    $fatal(1, "timeout");
  end

endmodule
